// File: rtl/recon_resp_tx_if.sv
// recon_resp_tx_if: AXI-Stream bundle (tdata/tkeep/tvalid/tlast/tready).
// recon_resp_tx uses it for the DMA payload input and the framed packet output.
interface recon_resp_tx_if #(
  parameter int DATA_WIDTH = 512,
  parameter int KEEP_WIDTH = DATA_WIDTH / 8
);
  logic [DATA_WIDTH-1:0] tdata;
  logic [KEEP_WIDTH-1:0] tkeep;
  logic                  tvalid;
  logic                  tlast;
  logic                  tready;

  modport master (output tdata, tkeep, tvalid, tlast, input tready);
  modport slave  (input tdata, tkeep, tvalid, tlast, output tready);
endinterface

// File: rtl/recon_resp_tx.sv
// recon_resp_tx: readback response framer.
// Accepts a readback request and issues one DMA read descriptor. It then
// frames the returned payload behind a 46-byte Ethernet/IP template and a
// 10-byte recon header (func_type 2'b10), so beat 0 payload starts at byte 56.
// Every output beat takes the next 8 input bytes on top of a 56-byte carry.
// Optional feature macro: RECON_RESP_TX_LEN_CHECK_EN. When it is defined, a
// payload byte counter places tlast at the requested size. Input that runs past
// the size is dropped, and any length mismatch pulses err_len_o.
//
// state       | meaning
// ST_IDLE     | request ready once the previous frame's last beat has drained
// ST_DESC     | descriptor valid, waiting for desc ready
// ST_STREAM   | one DMA beat in -> one output beat out
// ST_FLUSH    | emit the leftover carry bytes as the final beat
// ST_HDR_ONLY | size 0: emit the 56-byte header-only beat
// ST_DROP     | (length check only) discard input past size through input tlast
module recon_resp_tx #(
  parameter int DATA_WIDTH         = 512,
  parameter int KEEP_WIDTH         = DATA_WIDTH / 8,
  parameter int ADDR_WIDTH         = 34,
  parameter int DMA_DESC_LEN_WIDTH = 20,
  parameter int DMA_DESC_TAG_WIDTH = 8
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [367:0]                  hdr_template_i,
  input  logic                          s_req_valid_i,
  output logic                          s_req_ready_o,
  input  logic [ADDR_WIDTH-1:0]         s_req_addr_i,
  input  logic [7:0]                    s_req_id_i,
  input  logic [DMA_DESC_LEN_WIDTH-1:0] s_req_size_i,
  output logic [ADDR_WIDTH-1:0]         m_axis_read_desc_addr_o,
  output logic [DMA_DESC_LEN_WIDTH-1:0] m_axis_read_desc_len_o,
  output logic [DMA_DESC_TAG_WIDTH-1:0] m_axis_read_desc_tag_o,
  output logic                          m_axis_read_desc_valid_o,
  input  logic                          m_axis_read_desc_ready_i,
  recon_resp_tx_if.slave                s_axis_dma,
  recon_resp_tx_if.master               m_axis,
  output logic                          err_len_o
);

  typedef enum logic [2:0] {
    ST_IDLE, ST_DESC, ST_STREAM, ST_FLUSH, ST_HDR_ONLY, ST_DROP
  } state_t;

  state_t                        state_q;
  logic                          req_ready_q;
  logic [ADDR_WIDTH-1:0]         desc_addr_q;
  logic [DMA_DESC_LEN_WIDTH-1:0] desc_len_q;
  logic [DMA_DESC_TAG_WIDTH-1:0] desc_tag_q;
  logic                          desc_valid_q;
  logic [447:0]                  carry_q;
  logic [KEEP_WIDTH-1:0]         flush_keep_q;
  logic [DATA_WIDTH-1:0]         tdata_q;
  logic [KEEP_WIDTH-1:0]         tkeep_q;
  logic                          tvalid_q;
  logic                          tlast_q;

  logic                          out_free;
  logic                          dma_ready;
  logic                          dma_fire;
  logic                          req_fire;
  logic [79:0]                   recon_hdr;
  logic [KEEP_WIDTH-1:0]         eff_keep;
  logic                          eff_last;

`ifdef RECON_RESP_TX_LEN_CHECK_EN
  logic [DMA_DESC_LEN_WIDTH-1:0] rem_q;
  logic                          drop_q;
  logic                          err_len_q;
  logic [6:0]                    in_bytes;
  logic                          len_err;
  logic                          drop_after;

  function automatic logic [6:0] popcnt(input logic [63:0] k);
    logic [6:0] c;
    c = '0;
    for (int i = 0; i < 64; i++) c = c + {6'd0, k[i]};
    return c;
  endfunction

  function automatic logic [63:0] keep_of(input logic [6:0] n);
    logic [63:0] m;
    for (int i = 0; i < 64; i++) m[i] = (7'(i) < n);
    return m;
  endfunction

  assign in_bytes = popcnt(s_axis_dma.tkeep);
`endif

  assign out_free  = !tvalid_q || m_axis.tready;
`ifdef RECON_RESP_TX_LEN_CHECK_EN
  assign dma_ready = ((state_q == ST_STREAM) && out_free) || (state_q == ST_DROP);
`else
  assign dma_ready = (state_q == ST_STREAM) && out_free;
`endif
  assign dma_fire  = dma_ready && s_axis_dma.tvalid;
  assign req_fire  = req_ready_q && s_req_valid_i;
  assign recon_hdr = {3'b000, 32'(s_req_size_i), s_req_id_i, s_req_addr_i, 1'b1, 2'b10};

  // Effective end-of-payload for the current DMA beat: input tlast, or the byte count reaching size
  always_comb begin
    eff_keep = s_axis_dma.tkeep;
    eff_last = s_axis_dma.tlast;
`ifdef RECON_RESP_TX_LEN_CHECK_EN
    len_err    = 1'b0;
    drop_after = 1'b0;
    if (rem_q <= DMA_DESC_LEN_WIDTH'(in_bytes)) begin
      eff_keep   = keep_of(rem_q[6:0]);
      eff_last   = 1'b1;
      len_err    = !s_axis_dma.tlast || (rem_q != DMA_DESC_LEN_WIDTH'(in_bytes));
      drop_after = !s_axis_dma.tlast;
    end else if (s_axis_dma.tlast) begin
      len_err = 1'b1;
    end
`endif
  end

  // Framing FSM with registered request, descriptor and output stream signals
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      req_ready_q  <= 1'b0;
      desc_addr_q  <= '0;
      desc_len_q   <= '0;
      desc_tag_q   <= '0;
      desc_valid_q <= 1'b0;
      carry_q      <= '0;
      flush_keep_q <= '0;
      tdata_q      <= '0;
      tkeep_q      <= '0;
      tvalid_q     <= 1'b0;
      tlast_q      <= 1'b0;
`ifdef RECON_RESP_TX_LEN_CHECK_EN
      rem_q        <= '0;
      drop_q       <= 1'b0;
      err_len_q    <= 1'b0;
`endif
    end else begin
`ifdef RECON_RESP_TX_LEN_CHECK_EN
      err_len_q <= 1'b0;
`endif
      if (tvalid_q && m_axis.tready) tvalid_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (req_fire) begin
            req_ready_q <= 1'b0;
            carry_q     <= {recon_hdr, hdr_template_i};
            desc_addr_q <= s_req_addr_i;
            desc_len_q  <= s_req_size_i;
            desc_tag_q  <= DMA_DESC_TAG_WIDTH'(s_req_id_i);
`ifdef RECON_RESP_TX_LEN_CHECK_EN
            rem_q       <= s_req_size_i;
            drop_q      <= 1'b0;
`endif
            if (s_req_size_i == '0) begin
              state_q <= ST_HDR_ONLY;
            end else begin
              desc_valid_q <= 1'b1;
              state_q      <= ST_DESC;
            end
          end else if (out_free) begin
            // previous frame's last beat is gone (or handshakes now)
            req_ready_q <= 1'b1;
          end
        end
        ST_DESC: begin
          if (m_axis_read_desc_ready_i) begin
            desc_valid_q <= 1'b0;
            state_q      <= ST_STREAM;
          end
        end
        ST_STREAM: begin
          if (dma_fire) begin
            tdata_q      <= {s_axis_dma.tdata[63:0], carry_q};
            tkeep_q      <= {eff_keep[7:0], {56{1'b1}}};
            tvalid_q     <= 1'b1;
            tlast_q      <= eff_last && !eff_keep[8];
            carry_q      <= s_axis_dma.tdata[511:64];
            flush_keep_q <= {8'h00, eff_keep[63:8]};
`ifdef RECON_RESP_TX_LEN_CHECK_EN
            err_len_q    <= len_err;
            drop_q       <= drop_after;
            rem_q        <= rem_q - DMA_DESC_LEN_WIDTH'(in_bytes);
`endif
            if (eff_last) begin
              if (eff_keep[8]) state_q <= ST_FLUSH;
`ifdef RECON_RESP_TX_LEN_CHECK_EN
              else if (drop_after) state_q <= ST_DROP;
`endif
              else state_q <= ST_IDLE;
            end
          end
        end
        ST_FLUSH: begin
          if (out_free) begin
            tdata_q  <= {64'h0, carry_q};
            tkeep_q  <= flush_keep_q;
            tvalid_q <= 1'b1;
            tlast_q  <= 1'b1;
`ifdef RECON_RESP_TX_LEN_CHECK_EN
            state_q  <= drop_q ? ST_DROP : ST_IDLE;
`else
            state_q  <= ST_IDLE;
`endif
          end
        end
        ST_HDR_ONLY: begin
          if (out_free) begin
            tdata_q  <= {64'h0, carry_q};
            tkeep_q  <= 64'h00FF_FFFF_FFFF_FFFF;
            tvalid_q <= 1'b1;
            tlast_q  <= 1'b1;
            state_q  <= ST_IDLE;
          end
        end
`ifdef RECON_RESP_TX_LEN_CHECK_EN
        ST_DROP: begin
          if (dma_fire && s_axis_dma.tlast) state_q <= ST_IDLE;
        end
`endif
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign s_req_ready_o            = req_ready_q;
  assign m_axis_read_desc_addr_o  = desc_addr_q;
  assign m_axis_read_desc_len_o   = desc_len_q;
  assign m_axis_read_desc_tag_o   = desc_tag_q;
  assign m_axis_read_desc_valid_o = desc_valid_q;
  assign s_axis_dma.tready        = dma_ready;
  assign m_axis.tdata             = tdata_q;
  assign m_axis.tkeep             = tkeep_q;
  assign m_axis.tvalid            = tvalid_q;
  assign m_axis.tlast             = tlast_q;
`ifdef RECON_RESP_TX_LEN_CHECK_EN
  assign err_len_o                = err_len_q;
`else
  assign err_len_o                = 1'b0;
`endif

endmodule

// File: tb/tb_recon_resp_tx.sv
// tb_recon_resp_tx: directed bench for recon_resp_tx with a scoreboard of
// expected output beats built from a byte-level frame model.
`timescale 1ns/1ps
module tb_recon_resp_tx;

  typedef struct packed {
    logic [511:0] data;
    logic [63:0]  keep;
    logic         last;
  } beat_t;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [367:0] hdr_template;
  logic         s_req_valid;
  logic         s_req_ready;
  logic [33:0]  s_req_addr;
  logic [7:0]   s_req_id;
  logic [19:0]  s_req_size;
  logic [33:0]  desc_addr;
  logic [19:0]  desc_len;
  logic [7:0]   desc_tag;
  logic         desc_valid;
  logic         desc_ready;
  logic         err_len;

  recon_resp_tx_if dma_if ();
  recon_resp_tx_if m_if ();

  recon_resp_tx dut (
    .clk                      (clk),
    .rst_n                    (rst_n),
    .hdr_template_i           (hdr_template),
    .s_req_valid_i            (s_req_valid),
    .s_req_ready_o            (s_req_ready),
    .s_req_addr_i             (s_req_addr),
    .s_req_id_i               (s_req_id),
    .s_req_size_i             (s_req_size),
    .m_axis_read_desc_addr_o  (desc_addr),
    .m_axis_read_desc_len_o   (desc_len),
    .m_axis_read_desc_tag_o   (desc_tag),
    .m_axis_read_desc_valid_o (desc_valid),
    .m_axis_read_desc_ready_i (desc_ready),
    .s_axis_dma               (dma_if),
    .m_axis                   (m_if),
    .err_len_o                (err_len)
  );

  always #5 clk = ~clk;

  int    n_checks = 0;
  int    n_pass = 0;
  int    desc_hs = 0;
  int    err_cnt = 0;
  bit    tready_toggle = 1'b0;
  beat_t sb[$];

  task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  initial begin
    m_if.tready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      m_if.tready = tready_toggle ? ~m_if.tready : 1'b1;
    end
  end

  // output monitor: scoreboard pops, stall hold and DMA back-pressure checks
  bit           stall_prev = 1'b0;
  beat_t        prev_beat;
  beat_t        got_beat;
  beat_t        exp_beat;
  logic [511:0] mask;
  always @(negedge clk) begin
    if (!rst_n) begin
      stall_prev = 1'b0;
    end else begin
      if (desc_valid && desc_ready) desc_hs++;
      if (err_len) err_cnt++;
      got_beat = {m_if.tdata, m_if.tkeep, m_if.tlast};
      if (stall_prev) begin
        chk("hold_valid", m_if.tvalid, 1'b1);
        chk("hold_data", got_beat.data, prev_beat.data);
        chk("hold_ctl", {got_beat.keep, got_beat.last}, {prev_beat.keep, prev_beat.last});
      end
      if (m_if.tvalid && !m_if.tready) chk("dma_ready_in_stall", dma_if.tready, 1'b0);
      if (m_if.tvalid && m_if.tready) begin
        n_checks++;
        assert (sb.size() != 0) n_pass++;
        else $error("FAIL sb_extra_beat: observed beat keep %0h last %0b expected none", m_if.tkeep, m_if.tlast);
        if (sb.size() != 0) begin
          exp_beat = sb.pop_front();
          for (int k = 0; k < 64; k++) mask[8*k +: 8] = {8{exp_beat.keep[k]}};
          chk("beat_data", got_beat.data & mask, exp_beat.data);
          chk("beat_keep", got_beat.keep, exp_beat.keep);
          chk("beat_last", got_beat.last, exp_beat.last);
        end
      end
      stall_prev = m_if.tvalid && !m_if.tready;
      prev_beat  = got_beat;
    end
  end

  task automatic chk_zero(input string pfx);
    chk({pfx, "_req_ready"}, s_req_ready, 1'b0);
    chk({pfx, "_desc_valid"}, desc_valid, 1'b0);
    chk({pfx, "_desc_fields"}, {desc_addr, desc_len, desc_tag}, '0);
    chk({pfx, "_dma_ready"}, dma_if.tready, 1'b0);
    chk({pfx, "_m_tvalid"}, m_if.tvalid, 1'b0);
    chk({pfx, "_m_tdata"}, m_if.tdata, '0);
    chk({pfx, "_m_tkeep_tlast"}, {m_if.tkeep, m_if.tlast}, '0);
    chk({pfx, "_err_len"}, err_len, 1'b0);
  endtask

  task automatic run_frame(input logic [33:0] addr, input logic [7:0] id, input int size,
                           input int sent, input bit toggle, input int abort_after);
    logic [7:0]  fr[$];
    logic [7:0]  pay[$];
    logic [79:0] rh;
    beat_t       e;
    int          exp_len, exp_err, d0, e0, nb;
    bit          ok;
    tready_toggle = toggle;
    for (int i = 0; i < 46; i++) hdr_template[8*i +: 8] = 8'($urandom);
    rh = {3'b000, 32'(size), id, addr, 1'b1, 2'b10};
    for (int i = 0; i < 46; i++) fr.push_back(hdr_template[8*i +: 8]);
    for (int i = 0; i < 10; i++) fr.push_back(rh[8*i +: 8]);
    for (int i = 0; i < sent; i++) pay.push_back(8'($urandom));
    exp_len = 56 + sent;
    exp_err = 0;
`ifdef RECON_RESP_TX_LEN_CHECK_EN
    if (sent > size) exp_len = 56 + size;
    if (sent != size) exp_err = 1;
`endif
    for (int i = 0; i < exp_len - 56; i++) fr.push_back(pay[i]);
    for (int b = 0; b * 64 < exp_len; b++) begin
      e = '0;
      for (int k = 0; k < 64; k++) begin
        if (b * 64 + k < exp_len) begin
          e.data[8*k +: 8] = fr[b*64+k];
          e.keep[k] = 1'b1;
        end
      end
      e.last = ((b + 1) * 64 >= exp_len);
      sb.push_back(e);
    end
    d0 = desc_hs;
    e0 = err_cnt;

    s_req_addr  = addr;
    s_req_id    = id;
    s_req_size  = 20'(size);
    s_req_valid = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < 300 && !ok; i++) begin
      @(negedge clk);
      ok = s_req_ready;
    end
    chk("req_accept", ok, 1'b1);
    @(posedge clk);
    #1;
    s_req_valid  = 1'b0;
    hdr_template = ~hdr_template;

    if (size != 0) begin
      ok = 1'b0;
      for (int i = 0; i < 50 && !ok; i++) begin
        @(negedge clk);
        ok = desc_valid;
      end
      chk("desc_valid", ok, 1'b1);
      @(negedge clk);
      chk("desc_hold", desc_valid, 1'b1);
      chk("desc_addr", desc_addr, addr);
      chk("desc_len", desc_len, 20'(size));
      chk("desc_tag", desc_tag, id);
      desc_ready = 1'b1;
      @(posedge clk);
      #1;
      desc_ready = 1'b0;
    end

    nb = 0;
    for (int b = 0; b * 64 < sent; b++) begin
      if (abort_after >= 0 && nb == abort_after) break;
      dma_if.tdata = '0;
      dma_if.tkeep = '0;
      for (int k = 0; k < 64; k++) begin
        if (b * 64 + k < sent) begin
          dma_if.tdata[8*k +: 8] = pay[b*64+k];
          dma_if.tkeep[k] = 1'b1;
        end
      end
      dma_if.tlast  = ((b + 1) * 64 >= sent);
      dma_if.tvalid = 1'b1;
      ok = 1'b0;
      for (int i = 0; i < 200 && !ok; i++) begin
        @(negedge clk);
        ok = dma_if.tready;
      end
      chk("dma_accept", ok, 1'b1);
      @(posedge clk);
      #1;
      nb++;
    end
    dma_if.tvalid = 1'b0;
    dma_if.tlast  = 1'b0;

    if (abort_after < 0) begin
      ok = 1'b0;
      for (int i = 0; i < 400 && !ok; i++) begin
        @(negedge clk);
        ok = (sb.size() == 0);
      end
      chk("frame_drained", ok, 1'b1);
      repeat (2) @(posedge clk);
      #1;
      chk("desc_count", desc_hs - d0, (size != 0) ? 1 : 0);
      chk("err_len_count", err_cnt - e0, exp_err);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: observed no finish expected finish before time limit");
    $fatal(1);
  end

  initial begin
    s_req_valid   = 1'b0;
    s_req_addr    = '0;
    s_req_id      = '0;
    s_req_size    = '0;
    desc_ready    = 1'b0;
    hdr_template  = '0;
    dma_if.tvalid = 1'b0;
    dma_if.tdata  = '0;
    dma_if.tkeep  = '0;
    dma_if.tlast  = 1'b0;
    rst_n         = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk_zero("reset");
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("req_ready_after_reset", s_req_ready, 1'b1);

    run_frame(34'h0_0000_1000, 8'h11, 0, 0, 1'b0, -1);
    run_frame(34'h1_2345_6780, 8'h5A, 8, 8, 1'b0, -1);
    run_frame(34'h0_ABCD_0040, 8'hC3, 9, 9, 1'b0, -1);
    run_frame(34'h2_0000_0100, 8'h77, 200, 200, 1'b1, -1);
    run_frame(34'h3_FFFF_FFC0, 8'h01, 1, 1, 1'b1, -1);
    run_frame(34'h0_1111_2220, 8'h02, 63, 63, 1'b0, -1);
    run_frame(34'h0_3333_4440, 8'h03, 64, 64, 1'b1, -1);
    run_frame(34'h0_5555_6660, 8'h04, 65, 65, 1'b0, -1);
    run_frame(34'h1_7777_8880, 8'hFF, 130, 130, 1'b1, -1);

    run_frame(34'h0_DEAD_BEE0, 8'h99, 200, 200, 1'b0, 2);
    rst_n = 1'b0;
    #2;
    chk_zero("midframe_reset");
    sb.delete();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("req_ready_after_midreset", s_req_ready, 1'b1);
    run_frame(34'h0_CAFE_0000, 8'h42, 100, 100, 1'b1, -1);

`ifdef RECON_RESP_TX_LEN_CHECK_EN
    run_frame(34'h0_0000_2000, 8'h21, 100, 70, 1'b0, -1);
    run_frame(34'h0_0000_3000, 8'h22, 10, 128, 1'b0, -1);
    run_frame(34'h0_0000_4000, 8'h23, 20, 20, 1'b1, -1);
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
